// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES-128 key-schedule unit.
package aes_pkg;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam int NR = 10;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE_S} kx_state_t;

  // GF(2^8) multiply by x, used to step the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction
endpackage

// File: rtl/aes_key_expander_if.sv
// Start/done handshake, cipher key and round-key read bus of the key expander.
interface aes_key_expander_if;
  import aes_pkg::*;

  logic                      START;
  block_t                    KEY;
  logic                      DONE;
  logic                      BUSY;
  logic [128*(NR+1)-1:0]     KEY_SCHEDULE;
  logic [3:0]                RK_SEL;
  block_t                    ROUND_KEY;

  modport master (output START, KEY, RK_SEL,
                  input  DONE, BUSY, KEY_SCHEDULE, ROUND_KEY);
  modport slave  (input  START, KEY, RK_SEL,
                  output DONE, BUSY, KEY_SCHEDULE, ROUND_KEY);
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  always_comb begin
    y_o = 8'h00;
    case (a_i)
      8'h00: y_o = 8'h63; 8'h01: y_o = 8'h7c; 8'h02: y_o = 8'h77; 8'h03: y_o = 8'h7b; 8'h04: y_o = 8'hf2; 8'h05: y_o = 8'h6b; 8'h06: y_o = 8'h6f; 8'h07: y_o = 8'hc5;
      8'h08: y_o = 8'h30; 8'h09: y_o = 8'h01; 8'h0a: y_o = 8'h67; 8'h0b: y_o = 8'h2b; 8'h0c: y_o = 8'hfe; 8'h0d: y_o = 8'hd7; 8'h0e: y_o = 8'hab; 8'h0f: y_o = 8'h76;
      8'h10: y_o = 8'hca; 8'h11: y_o = 8'h82; 8'h12: y_o = 8'hc9; 8'h13: y_o = 8'h7d; 8'h14: y_o = 8'hfa; 8'h15: y_o = 8'h59; 8'h16: y_o = 8'h47; 8'h17: y_o = 8'hf0;
      8'h18: y_o = 8'had; 8'h19: y_o = 8'hd4; 8'h1a: y_o = 8'ha2; 8'h1b: y_o = 8'haf; 8'h1c: y_o = 8'h9c; 8'h1d: y_o = 8'ha4; 8'h1e: y_o = 8'h72; 8'h1f: y_o = 8'hc0;
      8'h20: y_o = 8'hb7; 8'h21: y_o = 8'hfd; 8'h22: y_o = 8'h93; 8'h23: y_o = 8'h26; 8'h24: y_o = 8'h36; 8'h25: y_o = 8'h3f; 8'h26: y_o = 8'hf7; 8'h27: y_o = 8'hcc;
      8'h28: y_o = 8'h34; 8'h29: y_o = 8'ha5; 8'h2a: y_o = 8'he5; 8'h2b: y_o = 8'hf1; 8'h2c: y_o = 8'h71; 8'h2d: y_o = 8'hd8; 8'h2e: y_o = 8'h31; 8'h2f: y_o = 8'h15;
      8'h30: y_o = 8'h04; 8'h31: y_o = 8'hc7; 8'h32: y_o = 8'h23; 8'h33: y_o = 8'hc3; 8'h34: y_o = 8'h18; 8'h35: y_o = 8'h96; 8'h36: y_o = 8'h05; 8'h37: y_o = 8'h9a;
      8'h38: y_o = 8'h07; 8'h39: y_o = 8'h12; 8'h3a: y_o = 8'h80; 8'h3b: y_o = 8'he2; 8'h3c: y_o = 8'heb; 8'h3d: y_o = 8'h27; 8'h3e: y_o = 8'hb2; 8'h3f: y_o = 8'h75;
      8'h40: y_o = 8'h09; 8'h41: y_o = 8'h83; 8'h42: y_o = 8'h2c; 8'h43: y_o = 8'h1a; 8'h44: y_o = 8'h1b; 8'h45: y_o = 8'h6e; 8'h46: y_o = 8'h5a; 8'h47: y_o = 8'ha0;
      8'h48: y_o = 8'h52; 8'h49: y_o = 8'h3b; 8'h4a: y_o = 8'hd6; 8'h4b: y_o = 8'hb3; 8'h4c: y_o = 8'h29; 8'h4d: y_o = 8'he3; 8'h4e: y_o = 8'h2f; 8'h4f: y_o = 8'h84;
      8'h50: y_o = 8'h53; 8'h51: y_o = 8'hd1; 8'h52: y_o = 8'h00; 8'h53: y_o = 8'hed; 8'h54: y_o = 8'h20; 8'h55: y_o = 8'hfc; 8'h56: y_o = 8'hb1; 8'h57: y_o = 8'h5b;
      8'h58: y_o = 8'h6a; 8'h59: y_o = 8'hcb; 8'h5a: y_o = 8'hbe; 8'h5b: y_o = 8'h39; 8'h5c: y_o = 8'h4a; 8'h5d: y_o = 8'h4c; 8'h5e: y_o = 8'h58; 8'h5f: y_o = 8'hcf;
      8'h60: y_o = 8'hd0; 8'h61: y_o = 8'hef; 8'h62: y_o = 8'haa; 8'h63: y_o = 8'hfb; 8'h64: y_o = 8'h43; 8'h65: y_o = 8'h4d; 8'h66: y_o = 8'h33; 8'h67: y_o = 8'h85;
      8'h68: y_o = 8'h45; 8'h69: y_o = 8'hf9; 8'h6a: y_o = 8'h02; 8'h6b: y_o = 8'h7f; 8'h6c: y_o = 8'h50; 8'h6d: y_o = 8'h3c; 8'h6e: y_o = 8'h9f; 8'h6f: y_o = 8'ha8;
      8'h70: y_o = 8'h51; 8'h71: y_o = 8'ha3; 8'h72: y_o = 8'h40; 8'h73: y_o = 8'h8f; 8'h74: y_o = 8'h92; 8'h75: y_o = 8'h9d; 8'h76: y_o = 8'h38; 8'h77: y_o = 8'hf5;
      8'h78: y_o = 8'hbc; 8'h79: y_o = 8'hb6; 8'h7a: y_o = 8'hda; 8'h7b: y_o = 8'h21; 8'h7c: y_o = 8'h10; 8'h7d: y_o = 8'hff; 8'h7e: y_o = 8'hf3; 8'h7f: y_o = 8'hd2;
      8'h80: y_o = 8'hcd; 8'h81: y_o = 8'h0c; 8'h82: y_o = 8'h13; 8'h83: y_o = 8'hec; 8'h84: y_o = 8'h5f; 8'h85: y_o = 8'h97; 8'h86: y_o = 8'h44; 8'h87: y_o = 8'h17;
      8'h88: y_o = 8'hc4; 8'h89: y_o = 8'ha7; 8'h8a: y_o = 8'h7e; 8'h8b: y_o = 8'h3d; 8'h8c: y_o = 8'h64; 8'h8d: y_o = 8'h5d; 8'h8e: y_o = 8'h19; 8'h8f: y_o = 8'h73;
      8'h90: y_o = 8'h60; 8'h91: y_o = 8'h81; 8'h92: y_o = 8'h4f; 8'h93: y_o = 8'hdc; 8'h94: y_o = 8'h22; 8'h95: y_o = 8'h2a; 8'h96: y_o = 8'h90; 8'h97: y_o = 8'h88;
      8'h98: y_o = 8'h46; 8'h99: y_o = 8'hee; 8'h9a: y_o = 8'hb8; 8'h9b: y_o = 8'h14; 8'h9c: y_o = 8'hde; 8'h9d: y_o = 8'h5e; 8'h9e: y_o = 8'h0b; 8'h9f: y_o = 8'hdb;
      8'ha0: y_o = 8'he0; 8'ha1: y_o = 8'h32; 8'ha2: y_o = 8'h3a; 8'ha3: y_o = 8'h0a; 8'ha4: y_o = 8'h49; 8'ha5: y_o = 8'h06; 8'ha6: y_o = 8'h24; 8'ha7: y_o = 8'h5c;
      8'ha8: y_o = 8'hc2; 8'ha9: y_o = 8'hd3; 8'haa: y_o = 8'hac; 8'hab: y_o = 8'h62; 8'hac: y_o = 8'h91; 8'had: y_o = 8'h95; 8'hae: y_o = 8'he4; 8'haf: y_o = 8'h79;
      8'hb0: y_o = 8'he7; 8'hb1: y_o = 8'hc8; 8'hb2: y_o = 8'h37; 8'hb3: y_o = 8'h6d; 8'hb4: y_o = 8'h8d; 8'hb5: y_o = 8'hd5; 8'hb6: y_o = 8'h4e; 8'hb7: y_o = 8'ha9;
      8'hb8: y_o = 8'h6c; 8'hb9: y_o = 8'h56; 8'hba: y_o = 8'hf4; 8'hbb: y_o = 8'hea; 8'hbc: y_o = 8'h65; 8'hbd: y_o = 8'h7a; 8'hbe: y_o = 8'hae; 8'hbf: y_o = 8'h08;
      8'hc0: y_o = 8'hba; 8'hc1: y_o = 8'h78; 8'hc2: y_o = 8'h25; 8'hc3: y_o = 8'h2e; 8'hc4: y_o = 8'h1c; 8'hc5: y_o = 8'ha6; 8'hc6: y_o = 8'hb4; 8'hc7: y_o = 8'hc6;
      8'hc8: y_o = 8'he8; 8'hc9: y_o = 8'hdd; 8'hca: y_o = 8'h74; 8'hcb: y_o = 8'h1f; 8'hcc: y_o = 8'h4b; 8'hcd: y_o = 8'hbd; 8'hce: y_o = 8'h8b; 8'hcf: y_o = 8'h8a;
      8'hd0: y_o = 8'h70; 8'hd1: y_o = 8'h3e; 8'hd2: y_o = 8'hb5; 8'hd3: y_o = 8'h66; 8'hd4: y_o = 8'h48; 8'hd5: y_o = 8'h03; 8'hd6: y_o = 8'hf6; 8'hd7: y_o = 8'h0e;
      8'hd8: y_o = 8'h61; 8'hd9: y_o = 8'h35; 8'hda: y_o = 8'h57; 8'hdb: y_o = 8'hb9; 8'hdc: y_o = 8'h86; 8'hdd: y_o = 8'hc1; 8'hde: y_o = 8'h1d; 8'hdf: y_o = 8'h9e;
      8'he0: y_o = 8'he1; 8'he1: y_o = 8'hf8; 8'he2: y_o = 8'h98; 8'he3: y_o = 8'h11; 8'he4: y_o = 8'h69; 8'he5: y_o = 8'hd9; 8'he6: y_o = 8'h8e; 8'he7: y_o = 8'h94;
      8'he8: y_o = 8'h9b; 8'he9: y_o = 8'h1e; 8'hea: y_o = 8'h87; 8'heb: y_o = 8'he9; 8'hec: y_o = 8'hce; 8'hed: y_o = 8'h55; 8'hee: y_o = 8'h28; 8'hef: y_o = 8'hdf;
      8'hf0: y_o = 8'h8c; 8'hf1: y_o = 8'ha1; 8'hf2: y_o = 8'h89; 8'hf3: y_o = 8'h0d; 8'hf4: y_o = 8'hbf; 8'hf5: y_o = 8'he6; 8'hf6: y_o = 8'h42; 8'hf7: y_o = 8'h68;
      8'hf8: y_o = 8'h41; 8'hf9: y_o = 8'h99; 8'hfa: y_o = 8'h2d; 8'hfb: y_o = 8'h0f; 8'hfc: y_o = 8'hb0; 8'hfd: y_o = 8'h54; 8'hfe: y_o = 8'hbb; 8'hff: y_o = 8'h16;
    endcase
  end
endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: one round key per clock into an 11-entry register file,
// read back flat or through an indexed port.
module aes_key_expander #(
  parameter int NR = 10  // only AES-128 (10) is supported
) (
  input  logic                CLK,
  input  logic                RESET,
  aes_key_expander_if.slave   kx
);
  import aes_pkg::*;

  kx_state_t  state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [7:0] rcon_q, rcon_d;
  block_t     rk_q [0:NR];
  logic       ld_key, wr_rk;

  block_t     prev, nxt, rk_mux;
  word_t      rot, sub, t, n0, n1, n2, n3;

  // Previous round key is rk[rnd-1]; out-of-range rnd reads as zero.
  always_comb begin
    prev = '0;
    for (int i = 0; i <= NR; i++)
      if (rnd_q == 4'(i + 1)) prev = rk_q[i];
  end

  assign rot = {prev[23:0], prev[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a_i(rot[8*b +: 8]), .y_o(sub[8*b +: 8]));
  end

  assign t   = sub ^ {rcon_q, 24'h0};
  assign n0  = prev[127:96] ^ t;
  assign n1  = prev[95:64]  ^ n0;
  assign n2  = prev[63:32]  ^ n1;
  assign n3  = prev[31:0]   ^ n2;
  assign nxt = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    ld_key  = 1'b0;
    wr_rk   = 1'b0;
    case (state_q)
      IDLE: if (kx.START) begin
        ld_key  = 1'b1;
        rnd_d   = 4'd1;
        rcon_d  = 8'h01;
        state_d = EXPAND;
      end
      EXPAND: begin
        wr_rk  = 1'b1;
        rnd_d  = rnd_q + 4'd1;
        rcon_d = xtime(rcon_q);
        if (rnd_q == 4'(NR)) state_d = DONE_S;
      end
      DONE_S: if (!kx.START) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      rcon_q  <= '0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      for (int i = 0; i <= NR; i++) begin
        if (ld_key && i == 0)                rk_q[i] <= kx.KEY;
        else if (wr_rk && rnd_q == 4'(i))    rk_q[i] <= nxt;
      end
    end
  end

  assign kx.DONE = (state_q == DONE_S);
  assign kx.BUSY = (state_q == EXPAND);

  for (genvar r = 0; r <= NR; r++) begin : g_flat
    assign kx.KEY_SCHEDULE[128*(NR+1)-1-128*r -: 128] = rk_q[r];
  end

  always_comb begin
    rk_mux = '0;
    for (int i = 0; i <= NR; i++)
      if (kx.RK_SEL == 4'(i)) rk_mux = rk_q[i];
  end
  assign kx.ROUND_KEY = rk_mux;
endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: FIPS-197 A.1 and all-zero keys,
// handshake timing, mid-run disturbances and reset abort.
module tb_aes_key_expander;
  logic clk = 1'b0;
  logic rst;
  always #50 clk = ~clk;

  aes_key_expander_if kx_if ();

  aes_key_expander #(.NR(10)) dut (.CLK(clk), .RESET(rst), .kx(kx_if));

  typedef struct {
    logic [3:0]   sel;
    logic [127:0] exp;
  } vec_t;

  vec_t a1_tab [16];
  vec_t z_tab  [3];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [127:0] KA1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    int r;
    kx_if.RK_SEL = v.sel;
    #1;
    chk($sformatf("%s ROUND_KEY[%0d]", tag, v.sel), kx_if.ROUND_KEY, v.exp);
    r = int'(v.sel);
    if (r <= 10)
      chk($sformatf("%s KEY_SCHEDULE[%0d]", tag, r), kx_if.KEY_SCHEDULE[1407-128*r -: 128], v.exp);
  endtask

  task automatic chk_a1(input string tag);
    for (int i = 0; i < 16; i++) chk_vec(tag, a1_tab[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at, busy_cnt, done_cnt;

    a1_tab[0]  = '{4'd0,  KA1};
    a1_tab[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    a1_tab[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    a1_tab[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    a1_tab[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    a1_tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    a1_tab[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    a1_tab[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    a1_tab[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    a1_tab[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    a1_tab[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    for (int i = 11; i < 16; i++) a1_tab[i] = '{4'(i), 128'h0};
    z_tab[0] = '{4'd0,  128'h0};
    z_tab[1] = '{4'd1,  128'h62636363626363636263636362636363};
    z_tab[2] = '{4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    // Reset state
    rst = 1'b1;
    kx_if.START = 1'b0;
    kx_if.KEY = '0;
    kx_if.RK_SEL = 4'd0;
    tick(); tick();
    chk("reset DONE", 128'(kx_if.DONE), 128'h0);
    chk("reset BUSY", 128'(kx_if.BUSY), 128'h0);
    chk("reset KEY_SCHEDULE nonzero", 128'(|kx_if.KEY_SCHEDULE), 128'h0);
    chk("reset ROUND_KEY", kx_if.ROUND_KEY, 128'h0);
    rst = 1'b0;
    tick();
    chk("idle BUSY", 128'(kx_if.BUSY), 128'h0);

    // A.1 key, START held 20 cycles
    kx_if.KEY = KA1;
    kx_if.START = 1'b1;
    done_at = -1; busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (kx_if.BUSY) busy_cnt++;
      if (kx_if.DONE) done_cnt++;
      if (kx_if.DONE && done_at < 0) done_at = i;
      if (i == 0) chk("a1 rk0 after start edge", kx_if.KEY_SCHEDULE[1407 -: 128], KA1);
      if (i == 1) chk("a1 rk1 after edge k+1", kx_if.KEY_SCHEDULE[1279 -: 128], a1_tab[1].exp);
    end
    chk("a1 DONE latency", 128'(done_at), 128'd10);
    chk("a1 BUSY cycles", 128'(busy_cnt), 128'd10);
    chk("a1 DONE held cycles", 128'(done_cnt), 128'd10);
    kx_if.START = 1'b0;
    #1;
    chk("DONE before edge after START drop", 128'(kx_if.DONE), 128'h1);
    tick();
    chk("DONE after START drop edge", 128'(kx_if.DONE), 128'h0);
    chk("BUSY in IDLE", 128'(kx_if.BUSY), 128'h0);
    kx_if.KEY = '1;
    tick(); tick(); tick();
    chk_a1("a1 retained");

    // Zero key; KEY changed at cycle 3 and START dropped at cycle 5 of EXPAND
    kx_if.KEY = '0;
    kx_if.START = 1'b1;
    done_at = -1; done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 2) kx_if.KEY = KA1;
      if (i == 4) kx_if.START = 1'b0;
      if (kx_if.DONE) done_cnt++;
      if (kx_if.DONE && done_at < 0) done_at = i;
    end
    chk("zero DONE latency", 128'(done_at), 128'd10);
    chk("zero DONE one cycle", 128'(done_cnt), 128'd1);
    for (int i = 0; i < 3; i++) chk_vec("zero", z_tab[i]);

    // Reset at cycle 6 of EXPAND, then fresh start
    kx_if.KEY = KA1;
    kx_if.START = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("BUSY before reset", 128'(kx_if.BUSY), 128'h1);
    rst = 1'b1;
    tick();
    chk("abort DONE", 128'(kx_if.DONE), 128'h0);
    chk("abort BUSY", 128'(kx_if.BUSY), 128'h0);
    chk("abort KEY_SCHEDULE nonzero", 128'(|kx_if.KEY_SCHEDULE), 128'h0);
    for (int s = 0; s < 16; s++) begin
      kx_if.RK_SEL = 4'(s);
      #1;
      chk($sformatf("abort ROUND_KEY[%0d]", s), kx_if.ROUND_KEY, 128'h0);
    end
    rst = 1'b0;
    done_at = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (kx_if.DONE && done_at < 0) done_at = i;
    end
    chk("restart DONE latency", 128'(done_at), 128'd10);
    kx_if.START = 1'b0;
    tick();
    chk_a1("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential AES-128 key-schedule unit between the Avalon AES register file and the AES decryption core. On a start request it captures the 128-bit cipher key and generates round keys 1..10 at one round per clock, storing all 11 round keys. The decryption core reads them in reverse order, either from the flat schedule bus or through the indexed read port. It uses the same level-held start / level done handshake as the register file's start and done registers.

## Interface
Parameters:
- NR, 10, number of rounds; fixed for AES-128, and no other value is supported.

Ports:
- CLK  in  1  clock
- RESET  in  1  reset, synchronous, active-high
- START  in  1  level start request, held high by the upstream start register
- KEY  in  128  cipher key; KEY[127:96] = w0 of FIPS-197, KEY[127:120] = key byte 0
- DONE  out  1  schedule complete; high only in state DONE_S
- BUSY  out  1  high in state EXPAND
- KEY_SCHEDULE  out  1408  round key r at bits [1407-128r -: 128]; r=0 is the cipher key
- RK_SEL  in  4  round-key index for the read port
- ROUND_KEY  out  128  combinational: round key RK_SEL for 0..10, zero for 11..15

## Operation
- States: IDLE, EXPAND, DONE_S. Internal registers: round counter rnd[3:0], rcon[7:0], schedule rk[0..10].
- IDLE, START=1: rk[0] <= KEY, rnd <= 1, rcon <= 8'h01, go to EXPAND. With START=0, stay in IDLE.
- EXPAND, each cycle, with p = rk[rnd-1] split into words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
  - rk[rnd] <= {n0,n1,n2,n3}, rnd <= rnd+1, rcon <= xtime(rcon)
  - xtime = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00), so the sequence is 01,02,04,08,10,20,40,80,1B,36.
- EXPAND with rnd=10: write rk[10] and go to DONE_S.
- DONE_S: stay while START=1. When START=0, go to IDLE the next edge.
- The schedule persists after returning to IDLE and is overwritten only by the next start.
- KEY is sampled only at the IDLE→EXPAND edge. Later KEY changes are ignored until the next start.
- A START deassert during EXPAND does not abort; expansion completes, DONE_S is entered and left on the following edge.
- A new start requires passing through IDLE: START must be low for at least one cycle after DONE.

## Timing
- Reset values: state IDLE, DONE=0, BUSY=0, rnd=0, rcon=0, all rk=0, so KEY_SCHEDULE=0 and ROUND_KEY=0.
- RESET mid-expansion aborts the expansion and clears everything on the same edge; RESET has priority over all other inputs.
- START sampled high at edge k:
  - rk[0] is valid after edge k.
  - rk[r] is valid after edge k+r.
  - DONE rises after edge k+10 and BUSY falls after the same edge.
- Total latency is 10 cycles from the start-sampling edge to DONE.
- DONE and BUSY are decoded from the state register only (glitch-free, no combinational path from START).
- ROUND_KEY is combinational from RK_SEL and rk, with zero added latency.

## Structure
- aes_pkg holds:
  - typedef word_t (logic [31:0]) and block_t (logic [127:0])
  - localparam NR = 10
  - state enum kx_state_t {IDLE, EXPAND, DONE_S}
  - function xtime
- Sub-module aes_sbox: combinational 8-bit forward S-box lookup (256-entry case). Instantiate it four times for SubWord.
- The schedule is an unpacked array of block_t flattened onto KEY_SCHEDULE.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, START held high:
  - rk[1] = a0fafe1788542cb123a339392a6c7605
  - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6
  - DONE rises exactly 10 cycles after the start edge.
- All-zero key:
  - rk[1] = 62636363626363636263636362636363
  - rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e
- Handshake: hold START for 20 cycles, then drop it:
  - DONE stays high until one edge after START falls.
  - BUSY is high for exactly 10 cycles.
  - Schedule is retained in IDLE.
- Mid-operation disturbance:
  - KEY changed at cycle 3 of EXPAND → the result still matches the originally sampled key.
  - START dropped at cycle 5 → completes, DONE high for one cycle.
- RESET asserted at cycle 6 of EXPAND → the next cycle shows IDLE, DONE=0, BUSY=0, ROUND_KEY=0 for all RK_SEL. A fresh start then produces the correct A.1 schedule.
- Read port after the A.1 run:
  - RK_SEL=0 gives the cipher key; RK_SEL=10 gives d014…0ca6.
  - RK_SEL=11..15 give 0.
  - Each ROUND_KEY output matches the corresponding KEY_SCHEDULE slice.
